sdcard_spi: RTL

SPI byte engine for the service processor's SD card port, instantiated inside the SP MMIO register block. It directly drives the sdcard_* pins. The MMIO block writes command/data bytes and reads responses through a small RX FIFO. A burst mode clocks out N dummy 0xFF bytes for block reads with no per-byte CPU write. All byte buses are big-endian [0:7]; bit 0 is the MSB and goes on the wire first.

---
 rtl/sdcard_pkg.sv | 15 +
 rtl/sdcard_rxfifo.sv | 67 ++++++
 rtl/sdcard_spi.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdcard_pkg.sv
// sdcard_spi shared types and constants.
// Used by the SPI byte engine and its RX FIFO.
package sdcard_pkg;

  localparam int BYTE_W = 8;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sdcard_rxfifo.sv
// sdcard_spi receive FIFO: synchronous, fall-through, depth 2**AW.
// Push while full only succeeds when a pop happens in the same cycle.
module sdcard_rxfifo
  import sdcard_pkg::*;
#(
  parameter int AW = 2,
  parameter int W  = BYTE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [0:W-1] push_data,
  input  logic         pop,
  output logic [0:W-1] data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

  logic [0:W-1] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] cnt;
  logic do_pop;
  logic do_push;

  assign empty = (cnt == '0);
  assign full = cnt[AW];
  assign level = cnt;
  assign data = mem[rd_ptr];

  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10: cnt <= cnt + CNT_ONE;
        2'b01: cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/sdcard_spi.sv
// sdcard_spi: SPI mode-0 byte engine with burst reads and RX FIFO.
// Optional CRC-16/XMODEM over received bits: define SDCARD_CRC16_EN.
module sdcard_spi
  import sdcard_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int FIFO_AW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [0:7]           tx_data,
  input  logic                 tx_stb,
  input  logic                 burst_stb,
  input  logic [0:15]          burst_len,
  output logic                 busy,
  output logic [0:7]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_pop,
  output logic                 rx_ovf,
  input  logic                 ovf_clr,
  output logic                 sdcard_cs,
  output logic                 sdcard_sck,
  output logic                 sdcard_mosi,
`ifdef SDCARD_CRC16_EN
  output logic [0:15]          crc16,
  input  logic                 crc_clr,
`endif
  input  logic                 sdcard_miso
);

  localparam logic [DIV_WIDTH-1:0] HC_ONE = DIV_WIDTH'(1);
  localparam logic [0:BYTE_W-1] BYTE_FF = '1;
  localparam logic [FIFO_AW:0] LVL_AF =
    (FIFO_AW + 1)'((1 << FIFO_AW) - 1);

  state_t state;
  state_t state_n;

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] hcnt;
  logic [2:0] nfall;
  logic sck_q;
  logic cs_q;
  logic [0:BYTE_W-1] tx_sr;
  logic [0:BYTE_W-1] rx_sr;
  logic [0:15] bcnt;
  logic burst_q;

  logic tick;
  logic rise;
  logic fall;
  logic last;
  logic load;
  logic load_ff;
  logic start_tx;
  logic start_burst;

  logic f_full;
  logic f_empty;
  logic [FIFO_AW:0] f_level;
  logic pop_eff;
  logic full_after;
  logic ovf_set;

  assign tick = (state == SHIFT) && (hcnt == div_q);
  assign rise = tick && !sck_q;
  assign fall = tick && sck_q;
  assign last = fall && (nfall == 3'd7);

  assign start_burst = (state == IDLE) && burst_stb;
  assign start_tx = (state == IDLE) && tx_stb && !burst_stb;

  assign pop_eff = rx_pop && !f_empty;
  assign full_after = ((f_level == LVL_AF) && !pop_eff)
                   || (f_full && pop_eff);
  assign ovf_set = last && f_full && !pop_eff;

  assign busy = (state != IDLE);
  assign sdcard_sck = sck_q;
  assign sdcard_mosi = tx_sr[0];
  assign sdcard_cs = cs_q;
  assign rx_valid = !f_empty;

  sdcard_rxfifo #(
    .AW(FIFO_AW),
    .W (BYTE_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (last),
    .push_data(rx_sr),
    .pop      (rx_pop),
    .data     (rx_data),
    .full     (f_full),
    .empty    (f_empty),
    .level    (f_level)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state; load marks a fresh byte starting next cycle.
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_ff = 1'b0;
    case (state)
      IDLE: begin
        if (burst_stb) begin
          if (f_full) begin
            state_n = WAIT;
          end else begin
            state_n = SHIFT;
            load = 1'b1;
            load_ff = 1'b1;
          end
        end else if (tx_stb) begin
          state_n = SHIFT;
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (last) begin
          if (!burst_q || (bcnt == '0)) begin
            state_n = IDLE;
          end else if (full_after) begin
            state_n = WAIT;
          end else begin
            load = 1'b1;
            load_ff = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!f_full) begin
          state_n = SHIFT;
          load = 1'b1;
          load_ff = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // SCK generation and MOSI/MISO shift registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      nfall <= '0;
      sck_q <= 1'b0;
      tx_sr <= BYTE_FF;
      rx_sr <= '0;
    end else if (load) begin
      hcnt <= '0;
      nfall <= '0;
      sck_q <= 1'b0;
      tx_sr <= load_ff ? BYTE_FF : tx_data;
    end else if (state == SHIFT) begin
      if (tick) begin
        hcnt <= '0;
        sck_q <= ~sck_q;
        if (fall) begin
          nfall <= nfall + 3'd1;
          tx_sr <= {tx_sr[1:BYTE_W-1], 1'b1};
        end
        if (rise) begin
          rx_sr <= {rx_sr[1:BYTE_W-1], sdcard_miso};
        end
      end else begin
        hcnt <= hcnt + HC_ONE;
      end
    end
  end

  // Divider latch, burst flag and remaining-byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      burst_q <= 1'b0;
      bcnt <= '0;
    end else begin
      if (start_tx || start_burst) begin
        div_q <= div_i;
      end
      if (start_burst) begin
        burst_q <= 1'b1;
        bcnt <= burst_len;
      end else if (start_tx) begin
        burst_q <= 1'b0;
      end else if (last && burst_q && (bcnt != '0)) begin
        bcnt <= bcnt - 16'd1;
      end
    end
  end

  // Chip select tracks cs_i only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q <= 1'b1;
    end else if (state == IDLE) begin
      cs_q <= cs_i;
    end
  end

  // Sticky overflow; a new overflow beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf <= 1'b0;
    end else if (ovf_set) begin
      rx_ovf <= 1'b1;
    end else if (ovf_clr) begin
      rx_ovf <= 1'b0;
    end
  end

`ifdef SDCARD_CRC16_EN
  logic crc_fb;

  assign crc_fb = crc16[0] ^ sdcard_miso;

  // CRC-16/XMODEM over each MISO bit as it is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc16 <= '0;
    end else if (crc_clr) begin
      crc16 <= '0;
    end else if (rise) begin
      crc16 <= {crc16[1:15], 1'b0} ^ (crc_fb ? CRC16_POLY : 16'h0000);
    end
  end
`endif

endmodule
